tour_cmd_seq: RTL
=================

# tour_cmd_seq

Consumer of the knight's-tour solver's move list. After the solver pulses `done`, this block reads the 24 solved moves one index at a time and turns each L-shaped knight move into two straight-line movement commands: a vertical leg, then a horizontal leg with fanfare. It hands these commands to the command processor with a ready/clear/response handshake. When no tour is running, it passes UART commands straight through to the command processor.

## Interface
Parameters:
- `NUM_MOVES`, default 24: moves per tour on the 5x5 board.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_tour`  in  1  one-cycle pulse; connect to solver `done`
- `mv_indx`  out  5  index of the move being read from the solver
- `move`  in  8  one-hot move at `mv_indx` (combinational from solver)
- `cmd_uart`  in  16  command from UART wrapper
- `cmd_rdy_uart`  in  1  UART command valid
- `clr_cmd_rdy_uart`  out  1  clears UART valid
- `cmd`  out  16  command to command processor
- `cmd_rdy`  out  1  `cmd` valid
- `clr_cmd_rdy`  in  1  command processor has taken `cmd`
- `send_resp`  in  1  command processor finished executing `cmd`
- `resp`  out  8  response byte for the UART

## Operation
Move encoding (bit: dx, dy):
- 0: −1, +2
- 1: +1, +2
- 2: −2, +1
- 3: −2, −1
- 4: −1, −2
- 5: +1, −2
- 6: +2, −1
- 7: +2, +1
- Non-one-hot input: the lowest set bit wins.
- `move == 0`: both legs are 0 squares, heading north for the vertical leg and east for the horizontal leg.

Command word is `{opcode[3:0], heading[7:0], squares[3:0]}`.
- Vertical leg: opcode `4'h2` (move), heading N `8'h00` if dy>0 else S `8'h7F`, squares = |dy|.
- Horizontal leg: opcode `4'h3` (move+fanfare), heading E `8'hBF` if dx>0 else W `8'h3F`, squares = |dx|.

FSM states: IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT.
- IDLE:
  - Passthrough: `cmd = cmd_uart`, `cmd_rdy = cmd_rdy_uart`, `clr_cmd_rdy_uart = clr_cmd_rdy`.
  - `start_tour` sets `mv_indx` to 0 and goes to VERT.
- VERT: `cmd` = vertical leg, `cmd_rdy` = 1; `clr_cmd_rdy` goes to VERT_WAIT.
- VERT_WAIT: `cmd_rdy` = 0; `send_resp` goes to HORZ.
- HORZ: `cmd` = horizontal leg, `cmd_rdy` = 1; `clr_cmd_rdy` goes to HORZ_WAIT.
- HORZ_WAIT: on `send_resp`:
  - If `mv_indx == NUM_MOVES-1`, go to IDLE and clear `mv_indx` to 0.
  - Otherwise increment `mv_indx` and go to VERT.
- Outside IDLE: `clr_cmd_rdy_uart` = 0 and UART inputs are ignored.

`resp` rules:
- `8'hA5` in IDLE.
- `8'hA5` in HORZ_WAIT when `mv_indx == NUM_MOVES-1` (final acknowledge).
- `8'h5A` in every other state.

Boundary rules:
- `start_tour` outside IDLE is ignored.
- `send_resp` in VERT or HORZ is ignored.
- `clr_cmd_rdy` in a WAIT state is ignored.
- `clr_cmd_rdy` and `send_resp` asserted in the same cycle in VERT/HORZ: only the clear acts.
- `rst_n` low at any time: IDLE and `mv_indx` = 0 immediately.

## Timing
- Reset values: state IDLE, `mv_indx` 0. `cmd`, `cmd_rdy`, `clr_cmd_rdy_uart` mirror the UART signals combinationally. `resp` = `8'hA5`.
- State and `mv_indx` are registered. `cmd`, `cmd_rdy`, `resp` and `clr_cmd_rdy_uart` are combinational from state, `move` and the UART inputs.
- `cmd` is valid in the first cycle of VERT/HORZ, because `move` is a combinational read of `mv_indx`.
- `start_tour` to `cmd_rdy` high: 1 cycle.
- `clr_cmd_rdy` to `cmd_rdy` low: 1 cycle.
- `send_resp` to the next `cmd_rdy` high: 1 cycle.
- A tour issues 2·`NUM_MOVES` = 48 commands.

## Structure
- `tour_pkg` holds the shared constants and typedef:
  - Opcodes `OP_MOVE = 4'h2`, `OP_FANFARE = 4'h3`.
  - Headings `HDG_N/W/S/E`.
  - Responses `RESP_ACK = 8'hA5`, `RESP_POS = 8'h5A`.
  - The state enum `tour_cmd_state_t`.
- Sub-module `knight_move_decode`: combinational; takes `move[7:0]` and outputs `vert_cmd[15:0]` and `horz_cmd[15:0]`.
- Top level holds the FSM, the `mv_indx` counter and the output muxing.

## Test plan
- **Passthrough:** reset; `cmd_uart = 16'h2002`, `cmd_rdy_uart = 1`, pulse `clr_cmd_rdy` → `cmd = 16'h2002`, `cmd_rdy = 1`, `clr_cmd_rdy_uart` pulses, `resp = 8'hA5`.
- **Single move 8'h02:** pulse `start_tour` → next cycle `cmd = 16'h2002`, `cmd_rdy = 1`. Clear, then `send_resp` → `resp = 8'h5A`, `cmd = 16'h3BF1`.
- **Move 8'h08:** vertical `16'h27F1`, horizontal `16'h33F2`.
- **All eight encodings:** exercise each bit → heading and squares match the table; `cmd_uart` toggling during the tour never reaches `cmd`.
- **Full 24-move tour:** solver move list → exactly 48 commands in index order. The final `send_resp` sees `resp = 8'hA5`, then the block is in IDLE with `mv_indx = 0`.
- **Disruptions:** `start_tour` at move 10 is ignored. Early `send_resp` in VERT does not advance. `rst_n` pulse at move 5 → IDLE, `mv_indx = 0`, passthrough restored.

Source files
------------

// File: rtl/tour_pkg.sv
// Shared constants, command layout and FSM state type for the tour command sequencer.
package tour_pkg;

    localparam int unsigned CMD_W     = 16;
    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned HEADING_W = 8;
    localparam int unsigned SQUARES_W = 4;
    localparam int unsigned RESP_W    = 8;
    localparam int unsigned MOVE_W    = 8;
    localparam int unsigned IDX_W     = 5;

    localparam logic [OPCODE_W-1:0]  OP_MOVE    = 4'h2;
    localparam logic [OPCODE_W-1:0]  OP_FANFARE = 4'h3;

    localparam logic [HEADING_W-1:0] HDG_N = 8'h00;
    localparam logic [HEADING_W-1:0] HDG_W = 8'h3F;
    localparam logic [HEADING_W-1:0] HDG_S = 8'h7F;
    localparam logic [HEADING_W-1:0] HDG_E = 8'hBF;

    localparam logic [RESP_W-1:0]    RESP_ACK = 8'hA5;
    localparam logic [RESP_W-1:0]    RESP_POS = 8'h5A;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [HEADING_W-1:0] heading;
        logic [SQUARES_W-1:0] squares;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        VERT_WAIT,
        HORZ,
        HORZ_WAIT
    } tour_cmd_state_t;

endpackage

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into a vertical move command and a horizontal
// move+fanfare command; the lowest set bit wins, an empty move gives two zero-length legs.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [MOVE_W-1:0] move,
    output logic [CMD_W-1:0]  vert_cmd,
    output logic [CMD_W-1:0]  horz_cmd
);

    logic                 w_dy_neg;
    logic                 w_dx_neg;
    logic [SQUARES_W-1:0] w_dy_mag;
    logic [SQUARES_W-1:0] w_dx_mag;
    cmd_t                 w_vert;
    cmd_t                 w_horz;

    // Displacement sign and magnitude per move bit
    always_comb begin
        w_dy_neg = 1'b0;
        w_dx_neg = 1'b0;
        w_dy_mag = '0;
        w_dx_mag = '0;
        casez (move)
            8'b???????1: begin w_dx_neg = 1'b1; w_dx_mag = 4'd1; w_dy_neg = 1'b0; w_dy_mag = 4'd2; end
            8'b??????10: begin w_dx_neg = 1'b0; w_dx_mag = 4'd1; w_dy_neg = 1'b0; w_dy_mag = 4'd2; end
            8'b?????100: begin w_dx_neg = 1'b1; w_dx_mag = 4'd2; w_dy_neg = 1'b0; w_dy_mag = 4'd1; end
            8'b????1000: begin w_dx_neg = 1'b1; w_dx_mag = 4'd2; w_dy_neg = 1'b1; w_dy_mag = 4'd1; end
            8'b???10000: begin w_dx_neg = 1'b1; w_dx_mag = 4'd1; w_dy_neg = 1'b1; w_dy_mag = 4'd2; end
            8'b??100000: begin w_dx_neg = 1'b0; w_dx_mag = 4'd1; w_dy_neg = 1'b1; w_dy_mag = 4'd2; end
            8'b?1000000: begin w_dx_neg = 1'b0; w_dx_mag = 4'd2; w_dy_neg = 1'b1; w_dy_mag = 4'd1; end
            8'b10000000: begin w_dx_neg = 1'b0; w_dx_mag = 4'd2; w_dy_neg = 1'b0; w_dy_mag = 4'd1; end
            default:     begin w_dx_neg = 1'b0; w_dx_mag = '0;   w_dy_neg = 1'b0; w_dy_mag = '0;   end
        endcase
    end

    always_comb begin
        w_vert.opcode  = OP_MOVE;
        w_vert.heading = w_dy_neg ? HDG_S : HDG_N;
        w_vert.squares = w_dy_mag;
        w_horz.opcode  = OP_FANFARE;
        w_horz.heading = w_dx_neg ? HDG_W : HDG_E;
        w_horz.squares = w_dx_mag;
    end

    assign vert_cmd = w_vert;
    assign horz_cmd = w_horz;

endmodule

// File: rtl/tour_cmd_seq.sv
// Walks the solved knight's-tour move list and issues two leg commands per move
// to the command processor; passes UART commands through while no tour is running.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int unsigned NUM_MOVES = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_tour,
    output logic [IDX_W-1:0]  mv_indx,
    input  logic [MOVE_W-1:0] move,
    input  logic [CMD_W-1:0]  cmd_uart,
    input  logic              cmd_rdy_uart,
    output logic              clr_cmd_rdy_uart,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic              send_resp,
    output logic [RESP_W-1:0] resp
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    tour_cmd_state_t  r_state;
    tour_cmd_state_t  w_state_nxt;
    logic [IDX_W-1:0] r_mv_indx;
    logic [IDX_W-1:0] w_mv_indx_nxt;
    logic [CMD_W-1:0] w_vert_cmd;
    logic [CMD_W-1:0] w_horz_cmd;
    logic             w_last;

    knight_move_decode u_decode (
        .move     (move),
        .vert_cmd (w_vert_cmd),
        .horz_cmd (w_horz_cmd)
    );

    assign w_last  = (r_mv_indx == LAST_IDX);
    assign mv_indx = r_mv_indx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mv_indx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mv_indx <= w_mv_indx_nxt;
        end
    end

    // Next state, move index and combinational handshake outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_mv_indx_nxt    = r_mv_indx;
        cmd              = '0;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_uart = 1'b0;
        resp             = RESP_POS;

        case (r_state)
            IDLE: begin
                cmd              = cmd_uart;
                cmd_rdy          = cmd_rdy_uart;
                clr_cmd_rdy_uart = clr_cmd_rdy;
                resp             = RESP_ACK;
                if (start_tour) begin
                    w_mv_indx_nxt = '0;
                    w_state_nxt   = VERT;
                end
            end
            VERT: begin
                cmd     = w_vert_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) begin
                    w_state_nxt = VERT_WAIT;
                end
            end
            VERT_WAIT: begin
                cmd = w_vert_cmd;
                if (send_resp) begin
                    w_state_nxt = HORZ;
                end
            end
            HORZ: begin
                cmd     = w_horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) begin
                    w_state_nxt = HORZ_WAIT;
                end
            end
            HORZ_WAIT: begin
                cmd = w_horz_cmd;
                if (w_last) begin
                    resp = RESP_ACK;
                end
                if (send_resp) begin
                    if (w_last) begin
                        w_mv_indx_nxt = '0;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_mv_indx_nxt = r_mv_indx + IDX_W'(1);
                        w_state_nxt   = VERT;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mv_indx_nxt = '0;
            end
        endcase
    end

endmodule
